// File: rtl/minv_pkg.sv
// Shared op encodings, STRIP FSM states and per-word next-value selects for minv_shreg_bank.
// Optional SHL1 support is enabled with MINV_SHL_EN.
package minv_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_LOAD  = 3'd1,
    OP_ROT   = 3'd2,
    OP_SHR1  = 3'd3,
    OP_STRIP = 3'd4,
    OP_SHL1  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  // SEL_WORD covers both LOAD and ROT; only the top word's source differs.
  typedef enum logic [2:0] {
    SEL_HOLD,
    SEL_WORD,
    SEL_SHR,
    SEL_SHL,
    SEL_CLR
  } sel_e;

endpackage

// File: rtl/minv_shreg_bank_if.sv
// Command-side bundle of minv_shreg_bank: handshake, opcode, load word and shift-in bit.
interface minv_shreg_bank_if #(
  parameter int unsigned WORD_W = 32
) ();
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [WORD_W-1:0] wr_data;
  logic              bit_in;

  modport master (
    output cmd_valid,
    output cmd_op,
    output wr_data,
    output bit_in,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  wr_data,
    input  bit_in,
    output cmd_ready
  );
endinterface

// File: rtl/minv_word_mux.sv
// Next-value select for one word of the shift register bank.
// The shift-left path exists only when MINV_SHL_EN is defined.
module minv_word_mux
  import minv_pkg::*;
#(
  parameter int unsigned WORD_W = 32
) (
  input  sel_e              sel_i,
  input  logic [WORD_W-1:0] cur_i,
  input  logic [WORD_W-1:0] up_word_i,
  input  logic              up_bit_i,
`ifdef MINV_SHL_EN
  input  logic              dn_bit_i,
`endif
  output logic [WORD_W-1:0] nxt_o
);

  always_comb begin
    nxt_o = cur_i;
    case (sel_i)
      SEL_WORD: nxt_o = up_word_i;
      SEL_SHR:  nxt_o = {up_bit_i, cur_i[WORD_W-1:1]};
`ifdef MINV_SHL_EN
      SEL_SHL:  nxt_o = {cur_i[WORD_W-2:0], dn_bit_i};
`endif
      SEL_CLR:  nxt_o = '0;
      default:  nxt_o = cur_i;
    endcase
  end

endmodule

// File: rtl/minv_shreg_bank.sv
// Multi-word load/rotate/shift register bank with a trailing-zero STRIP command.
// Define MINV_SHL_EN to enable op 5 (SHL1); otherwise op 5 is a NOP.
module minv_shreg_bank
  import minv_pkg::*;
#(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned NWORDS = 8,
  parameter int unsigned CNT_W  = $clog2(WORD_W * NWORDS + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  minv_shreg_bank_if.slave           cmd,
  output logic [WORD_W*NWORDS-1:0]   reg_q,
  output logic [WORD_W-1:0]          rd_data,
  output logic                       bit_out,
  output logic                       msb_out,
  output logic                       is_zero,
  output logic                       is_odd,
  output logic                       busy,
  output logic                       done,
  output logic [CNT_W-1:0]           strip_cnt
);

  localparam int unsigned TOTAL = WORD_W * NWORDS;

  logic [TOTAL-1:0]  data_q, data_d;
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  sel_e              sel;
  logic              is_load;
  logic              accept;
  logic [WORD_W-1:0] top_word;
  logic              top_bit;

  assign cmd.cmd_ready = (state_q == S_IDLE) & ~clr & ~rst;
  assign accept        = cmd.cmd_valid & cmd.cmd_ready;

  // Top word refills from wr_data on LOAD and from word 0 on ROT; STRIP shifts in zeros.
  assign top_word = is_load ? cmd.wr_data : data_q[WORD_W-1:0];
  assign top_bit  = (state_q == S_RUN) ? 1'b0 : cmd.bit_in;

  for (genvar i = 0; i < NWORDS; i++) begin : g_word
    logic [WORD_W-1:0] up_word;
    logic              up_bit;
    if (i == NWORDS - 1) begin : g_top
      assign up_word = top_word;
      assign up_bit  = top_bit;
    end else begin : g_mid
      assign up_word = data_q[(i+1)*WORD_W +: WORD_W];
      assign up_bit  = data_q[(i+1)*WORD_W];
    end
`ifdef MINV_SHL_EN
    logic dn_bit;
    if (i == 0) begin : g_bot
      assign dn_bit = cmd.bit_in;
    end else begin : g_up
      assign dn_bit = data_q[i*WORD_W-1];
    end
`endif
    minv_word_mux #(
      .WORD_W(WORD_W)
    ) u_mux (
      .sel_i    (sel),
      .cur_i    (data_q[i*WORD_W +: WORD_W]),
      .up_word_i(up_word),
      .up_bit_i (up_bit),
`ifdef MINV_SHL_EN
      .dn_bit_i (dn_bit),
`endif
      .nxt_o    (data_d[i*WORD_W +: WORD_W])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel     = SEL_HOLD;
    is_load = 1'b0;
    if (clr) begin
      state_d = S_IDLE;
      sel     = SEL_CLR;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            case (op_e'(cmd.cmd_op))
              OP_LOAD: begin
                sel     = SEL_WORD;
                is_load = 1'b1;
              end
              OP_ROT:  sel = SEL_WORD;
              OP_SHR1: sel = SEL_SHR;
              OP_STRIP: begin
                cnt_d   = '0;
                state_d = (data_q[0] | is_zero) ? S_DONE : S_RUN;
              end
`ifdef MINV_SHL_EN
              OP_SHL1: sel = SEL_SHL;
`endif
              default: ;
            endcase
          end
        end
        S_RUN: begin
          sel   = SEL_SHR;
          cnt_d = cnt_q + CNT_W'(1);
          if (data_q[1]) state_d = S_DONE;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      data_q  <= data_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign reg_q     = data_q;
  assign rd_data   = data_q[WORD_W-1:0];
  assign bit_out   = data_q[0];
  assign msb_out   = data_q[TOTAL-1];
  assign is_zero   = ~|data_q;
  assign is_odd    = data_q[0];
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign strip_cnt = cnt_q;

endmodule

// File: tb/tb_minv_shreg_bank.sv
// Self-checking bench for minv_shreg_bank: operand-level model compared every cycle,
// plus directed literal checks. SHL1 expectations follow MINV_SHL_EN.
module tb_minv_shreg_bank;
  import minv_pkg::*;

  localparam int W  = 32;
  localparam int N  = 8;
  localparam int T  = W * N;
  localparam int CW = $clog2(T + 1);

  logic clk = 1'b0;
  logic rst;
  logic clr;
  always #5 clk = ~clk;

  minv_shreg_bank_if #(.WORD_W(W)) cmd_if ();

  logic [T-1:0]  reg_q;
  logic [W-1:0]  rd_data;
  logic          bit_out, msb_out, is_zero, is_odd, busy, done;
  logic [CW-1:0] strip_cnt;

  minv_shreg_bank #(
    .WORD_W(W),
    .NWORDS(N)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .cmd      (cmd_if.slave),
    .reg_q    (reg_q),
    .rd_data  (rd_data),
    .bit_out  (bit_out),
    .msb_out  (msb_out),
    .is_zero  (is_zero),
    .is_odd   (is_odd),
    .busy     (busy),
    .done     (done),
    .strip_cnt(strip_cnt)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(string name, logic [T-1:0] act, logic [T-1:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Operand-level model: STRIP is described by its trailing-zero count k and elapsed cycles t.
  logic [T-1:0] m_reg, m_orig;
  int           m_cnt, m_t, m_k;
  bit           chk_en = 1'b0;

  function automatic int tz(logic [T-1:0] v);
    if (v == '0) return 0;
    for (int i = 0; i < T; i++) if (v[i]) return i;
    return 0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_reg = '0; m_cnt = 0; m_t = 0;
    end else if (clr) begin
      m_reg = '0; m_t = 0;
    end else if (m_t > 0) begin
      if (m_t == m_k + 1) m_t = 0;
      else begin
        m_t++;
        m_reg = m_orig >> (m_t - 1);
        m_cnt = m_t - 1;
      end
    end else if (cmd_if.cmd_valid) begin
      case (cmd_if.cmd_op)
        3'd1: m_reg = {cmd_if.wr_data, m_reg[T-1:W]};
        3'd2: m_reg = {m_reg[W-1:0], m_reg[T-1:W]};
        3'd3: m_reg = {cmd_if.bit_in, m_reg[T-1:1]};
        3'd4: begin
          m_orig = m_reg; m_k = tz(m_reg); m_cnt = 0; m_t = 1;
        end
`ifdef MINV_SHL_EN
        3'd5: m_reg = {m_reg[T-2:0], cmd_if.bit_in};
`endif
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("reg_q", reg_q, m_reg);
      chk("rd_data", T'(rd_data), T'(m_reg[W-1:0]));
      chk("bit_out", T'(bit_out), T'(m_reg[0]));
      chk("msb_out", T'(msb_out), T'(m_reg[T-1]));
      chk("is_zero", T'(is_zero), T'(m_reg == '0));
      chk("is_odd", T'(is_odd), T'(m_reg[0]));
      chk("busy", T'(busy), T'(m_t > 0));
      chk("done", T'(done), T'(m_t > 0 && m_t == m_k + 1));
      chk("strip_cnt", T'(strip_cnt), T'(m_cnt));
      chk("cmd_ready", T'(cmd_if.cmd_ready), T'(m_t == 0 && !clr && !rst));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(logic [2:0] op, logic [W-1:0] d, logic b);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.wr_data   = d;
    cmd_if.bit_in    = b;
    tick();
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic load256(logic [T-1:0] v);
    for (int i = 0; i < N; i++) issue(OP_LOAD, v[i*W +: W], 1'b0);
  endtask

  localparam logic [T-1:0] LoadPat = {32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};

  initial begin
    int n;
    rst = 1'b1; clr = 1'b0;
    cmd_if.cmd_valid = 1'b0; cmd_if.cmd_op = '0; cmd_if.wr_data = '0; cmd_if.bit_in = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_reg", reg_q, '0);
    chk("rst_cnt", T'(strip_cnt), '0);
    chk("rst_busy", T'(busy), '0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", T'(cmd_if.cmd_ready), T'(1));

    for (int i = 0; i < N; i++) issue(OP_LOAD, W'(i + 1), 1'b0);
    chk("load_reg", reg_q, LoadPat);
    chk("load_rd", T'(rd_data), T'(1));
    chk("load_nz", T'(is_zero), '0);

    for (int i = 0; i < N; i++) begin
      chk("rot_rd", T'(rd_data), T'(i + 1));
      issue(OP_ROT, '0, 1'b0);
    end
    chk("rot_restore", reg_q, LoadPat);

    load256(T'(32'h28));
    issue(OP_STRIP, '0, 1'b0);
    chk("strip_busy", T'(busy), T'(1));
    chk("strip_not_ready", T'(cmd_if.cmd_ready), '0);
    n = 1;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    chk("strip_latency", T'(n), T'(4));
    chk("strip_cnt3", T'(strip_cnt), T'(3));
    chk("strip_reg5", reg_q, T'(5));
    tick();
    chk("strip_idle", T'(busy), '0);

    clr = 1'b1;
    tick();
    clr = 1'b0;
    issue(OP_STRIP, '0, 1'b0);
    chk("zero_done", T'(done), T'(1));
    chk("zero_cnt", T'(strip_cnt), '0);
    chk("zero_is_zero", T'(is_zero), T'(1));
    tick();

    load256(T'(7));
    issue(OP_STRIP, '0, 1'b0);
    chk("odd_done", T'(done), T'(1));
    chk("odd_cnt", T'(strip_cnt), '0);
    chk("odd_reg", reg_q, T'(7));
    tick();

    // Abort a long STRIP; a LOAD held on the bus meanwhile must be dropped.
    load256(T'(1) << 200);
    issue(OP_STRIP, '0, 1'b0);
    cmd_if.cmd_valid = 1'b1; cmd_if.cmd_op = OP_LOAD; cmd_if.wr_data = 32'hdead;
    repeat (4) tick();
    chk("abort_busy", T'(busy), T'(1));
    chk("abort_cnt_pre", T'(strip_cnt), T'(4));
    clr = 1'b1;
    tick();
    clr = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    #1;
    chk("abort_reg", reg_q, '0);
    chk("abort_busy0", T'(busy), '0);
    chk("abort_nodone", T'(done), '0);
    chk("abort_ready", T'(cmd_if.cmd_ready), T'(1));
    chk("abort_cnt_held", T'(strip_cnt), T'(4));
    repeat (2) tick();

    load256(T'(3));
    issue(OP_SHR1, '0, 1'b1);
    chk("shr1", reg_q, (T'(1) << 255) | T'(1));
    issue(3'd6, 32'hffff_ffff, 1'b1);
    chk("undef_op", reg_q, (T'(1) << 255) | T'(1));

    load256(T'(1) << 255);
    issue(3'd5, '0, 1'b0);
`ifdef MINV_SHL_EN
    chk("shl1", reg_q, '0);
`else
    chk("op5_nop", reg_q, T'(1) << 255);
`endif
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/minv_shreg_bank.md
Name: minv_shreg_bank

Overview:
- Parametrised multi-word shift register bank for the modular-inverse datapath; successor to the single 32-bit load/rotate/shift register slice.
- Holds one NWORDS x WORD_W operand (default 256 bits).
- Supports word-serial load, cyclic word rotate for word-serial readout, and 1-bit right shift with an external MSB bit.
- Adds a multi-cycle "strip trailing zeros" command with a count result, used for the halving steps of binary extended Euclid.

Parameters:
WORD_W, 32, word width in bits
NWORDS, 8, number of words; TOTAL = WORD_W*NWORDS
CNT_W, $clog2(WORD_W*NWORDS+1), width of strip_cnt

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
clr  in  1  synchronous clear of register contents and FSM
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_op  in  3  0 NOP, 1 LOAD, 2 ROT, 3 SHR1, 4 STRIP, 5 SHL1 (optional), others NOP
wr_data  in  WORD_W  word for LOAD
bit_in  in  1  bit entering MSB on SHR1 (LSB on SHL1)
reg_q  out  TOTAL  full register contents
rd_data  out  WORD_W  word 0 (bits WORD_W-1:0)
bit_out  out  1  reg_q[0]
msb_out  out  1  reg_q[TOTAL-1]
is_zero  out  1  reg_q == 0
is_odd  out  1  reg_q[0]
busy  out  1  high in STRIP RUN/DONE states
done  out  1  one-cycle pulse when STRIP completes
strip_cnt  out  CNT_W  trailing zeros removed by last STRIP; held until next STRIP accept

Behaviour:
- Reset (rst=1): reg_q=0, FSM=IDLE, busy=0, done=0, strip_cnt=0. Same effect from clr=1, except strip_cnt is held. rst has priority over clr.
- cmd_ready = (state==IDLE) & ~clr & ~rst. A command issued while not ready is dropped, not queued.
- Single-cycle ops take effect at the accepting edge; reg_q is visible the next cycle.
- LOAD: reg_q <= {wr_data, reg_q[TOTAL-1:WORD_W]}. Word shifts in at the top and the existing contents shift down one word. After NWORDS loads, the first loaded word is word 0.
- ROT: reg_q <= {reg_q[WORD_W-1:0], reg_q[TOTAL-1:WORD_W]}. Word 0 wraps to the top. NWORDS ROTs restore the original value. rd_data before each ROT gives word-serial readout, low word first.
- SHR1: reg_q <= {bit_in, reg_q[TOTAL-1:1]}. Bit 0 is lost; sample bit_out before the edge.
- STRIP FSM, states IDLE, RUN, DONE:
  - IDLE, accept STRIP: clear strip_cnt. If reg_q[0]=1 or reg_q==0, go to DONE; otherwise go to RUN.
  - RUN: each cycle, reg_q <= {1'b0, reg_q[TOTAL-1:1]} and strip_cnt++. When the shifted value has bit 0 = 1 (i.e. reg_q[1]=1 before the shift), go to DONE.
  - DONE: done=1 for one cycle, then IDLE.
  - Latency for k trailing zeros: done asserted k+1 cycles after accept. k=0 gives done the cycle after accept.
  - strip_cnt cannot exceed TOTAL-1, because a zero operand never enters RUN.
- clr or rst during RUN/DONE: abort to IDLE, no done pulse, reg_q=0.
- Undefined cmd_op values and NOP: accepted, no state change.

Optional Feature:
- Macro MINV_SHL_EN.
- Defined: op 5 SHL1 gives reg_q <= {reg_q[TOTAL-2:0], bit_in}; the MSB is lost (sample msb_out before the edge).
- Undefined: op 5 is treated as NOP, and the shift-left mux is not built.

Decomposition:
- Shared package minv_pkg holds:
  - op encodings: OP_NOP, OP_LOAD, OP_ROT, OP_SHR1, OP_STRIP, OP_SHL1
  - FSM state typedef: S_IDLE, S_RUN, S_DONE
- One natural sub-module, minv_word_mux: per-word next-value select (hold/load/rotate/shift/clear), instantiated NWORDS times. The FSM and counter stay in the top.

Test Plan:
- rst, then 8 LOADs of 0x00000001..0x00000008 -> reg_q word i = i+1; rd_data=0x00000001; is_zero=0.
- After the load, 8 ROTs with rd_data sampled each cycle -> sequence 1..8; final reg_q equals its pre-rotate value.
- reg_q=0x28, STRIP -> 3 RUN cycles, done 4 cycles after accept, strip_cnt=3, reg_q=0x5, cmd_ready low during busy.
- reg_q=0, STRIP -> done the next cycle, strip_cnt=0, is_zero=1. reg_q=0x7, STRIP -> done the next cycle, strip_cnt=0, reg_q unchanged.
- reg_q=1<<200, STRIP, assert clr on the 5th RUN cycle -> reg_q=0, FSM back to IDLE, no done pulse, cmd_ready high the next cycle.
- reg_q=0x3, SHR1 with bit_in=1 -> reg_q=(1<<255)|0x1. With MINV_SHL_EN, SHL1 with bit_in=0 from 1<<255 -> reg_q=0.
